// File: rtl/commit_flush_sequencer_if.sv
// Commit/cache/MMU/frontend handshake bundle for commit_flush_sequencer.
// master: commit stage and flush targets; slave: the sequencer itself.
interface commit_flush_sequencer_if #(
  parameter int unsigned PC_WIDTH = 64
) ();
  logic                fence_req_i;
  logic                fence_i_req_i;
  logic                sfence_vma_req_i;
  logic                ex_valid_i;
  logic                halt_i;
  logic [PC_WIDTH-1:0] pc_commit_i;
  logic                dcache_flush_ack_i;
  logic                flush_dcache_o;
  logic                flush_icache_o;
  logic                flush_tlb_o;
  logic                flush_pipeline_o;
  logic                set_pc_o;
  logic [PC_WIDTH-1:0] restart_pc_o;
  logic                busy_o;

  modport master (
    output fence_req_i, fence_i_req_i, sfence_vma_req_i, ex_valid_i, halt_i,
           pc_commit_i, dcache_flush_ack_i,
    input  flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipeline_o,
           set_pc_o, restart_pc_o, busy_o
  );

  modport slave (
    input  fence_req_i, fence_i_req_i, sfence_vma_req_i, ex_valid_i, halt_i,
           pc_commit_i, dcache_flush_ack_i,
    output flush_dcache_o, flush_icache_o, flush_tlb_o, flush_pipeline_o,
           set_pc_o, restart_pc_o, busy_o
  );
endinterface

// File: rtl/commit_flush_sequencer.sv
// Sequences FENCE / FENCE.I / SFENCE.VMA at commit: D$ flush handshake,
// I$ invalidate, TLB flush, then pipeline flush and frontend redirect.
// Optional macro FLUSH_PERF_CNT_EN adds busy-cycle and flush-count outputs.
module commit_flush_sequencer #(
  parameter int unsigned PC_WIDTH            = 64,
  parameter int unsigned ICACHE_FLUSH_CYCLES = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  commit_flush_sequencer_if.slave   bus
`ifdef FLUSH_PERF_CNT_EN
  ,
  output logic [31:0]               flush_cycles_o,
  output logic [15:0]               flush_count_o
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    FLUSH_DCACHE,
    FLUSH_ICACHE,
    FLUSH_TLB,
    RESTART
  } state_e;

  localparam logic [3:0] IC_LAST = 4'(ICACHE_FLUSH_CYCLES - 1);

  state_e              state_q, state_d;
  logic                is_fence_i_q, is_fence_i_d;
  logic [3:0]          ic_cnt_q, ic_cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                req_any;
  logic                busy;

  assign req_any = bus.fence_req_i | bus.fence_i_req_i | bus.sfence_vma_req_i;
  assign busy    = (state_q != IDLE);

  // State and sequence context registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      is_fence_i_q <= 1'b0;
      ic_cnt_q     <= '0;
      pc_q         <= '0;
    end else begin
      state_q      <= state_d;
      is_fence_i_q <= is_fence_i_d;
      ic_cnt_q     <= ic_cnt_d;
      pc_q         <= pc_d;
    end
  end

  // Next-state logic and Moore output decode
  always_comb begin
    state_d              = state_q;
    is_fence_i_d         = is_fence_i_q;
    ic_cnt_d             = ic_cnt_q;
    pc_d                 = pc_q;
    bus.flush_dcache_o   = 1'b0;
    bus.flush_icache_o   = 1'b0;
    bus.flush_tlb_o      = 1'b0;
    bus.flush_pipeline_o = 1'b0;
    bus.set_pc_o         = 1'b0;
    bus.restart_pc_o     = '0;
    bus.busy_o           = busy;
    unique case (state_q)
      IDLE: begin
        if (req_any && !bus.ex_valid_i && !bus.halt_i) begin
          pc_d = bus.pc_commit_i + PC_WIDTH'(4);
          // FENCE.I outranks FENCE, and either outranks SFENCE.VMA
          if (bus.fence_i_req_i || bus.fence_req_i) begin
            state_d      = FLUSH_DCACHE;
            is_fence_i_d = bus.fence_i_req_i;
          end else begin
            state_d = FLUSH_TLB;
          end
        end
      end
      FLUSH_DCACHE: begin
        bus.flush_dcache_o = 1'b1;
        if (bus.dcache_flush_ack_i) begin
          if (is_fence_i_q) begin
            state_d  = FLUSH_ICACHE;
            ic_cnt_d = '0;
          end else begin
            state_d = RESTART;
          end
        end
      end
      FLUSH_ICACHE: begin
        bus.flush_icache_o = 1'b1;
        if (ic_cnt_q == IC_LAST) begin
          state_d = RESTART;
        end else begin
          ic_cnt_d = ic_cnt_q + 4'd1;
        end
      end
      FLUSH_TLB: begin
        bus.flush_tlb_o = 1'b1;
        state_d         = RESTART;
      end
      RESTART: begin
        bus.flush_pipeline_o = 1'b1;
        bus.set_pc_o         = 1'b1;
        bus.restart_pc_o     = pc_q;
        state_d              = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef FLUSH_PERF_CNT_EN
  // Busy-cycle counter (saturating) and completed-sequence counter (wrapping)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flush_cycles_o <= '0;
      flush_count_o  <= '0;
    end else begin
      if (busy && (flush_cycles_o != '1)) begin
        flush_cycles_o <= flush_cycles_o + 32'd1;
      end
      if (state_q == RESTART) begin
        flush_count_o <= flush_count_o + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_commit_flush_sequencer.sv
// Bench for commit_flush_sequencer: two instances (I$ flush of 1 and 4
// cycles) share stimulus; a schedule-based model predicts every output.
`timescale 1ns/1ps
module tb_commit_flush_sequencer;
  localparam int unsigned PCW = 64;

  logic clk = 1'b0;
  logic rst_n;
  logic fence, fence_i, sfence, ex, halt, ack;
  logic [PCW-1:0] pc;

  always #5 clk = ~clk;

  commit_flush_sequencer_if #(.PC_WIDTH(PCW)) bus0 ();
  commit_flush_sequencer_if #(.PC_WIDTH(PCW)) bus1 ();

  assign bus0.fence_req_i = fence;      assign bus1.fence_req_i = fence;
  assign bus0.fence_i_req_i = fence_i;  assign bus1.fence_i_req_i = fence_i;
  assign bus0.sfence_vma_req_i = sfence; assign bus1.sfence_vma_req_i = sfence;
  assign bus0.ex_valid_i = ex;          assign bus1.ex_valid_i = ex;
  assign bus0.halt_i = halt;            assign bus1.halt_i = halt;
  assign bus0.pc_commit_i = pc;         assign bus1.pc_commit_i = pc;
  assign bus0.dcache_flush_ack_i = ack; assign bus1.dcache_flush_ack_i = ack;

`ifdef FLUSH_PERF_CNT_EN
  logic [31:0] cyc_o [2];
  logic [15:0] cnt_o [2];
`endif

  commit_flush_sequencer #(.PC_WIDTH(PCW), .ICACHE_FLUSH_CYCLES(1)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave)
`ifdef FLUSH_PERF_CNT_EN
    , .flush_cycles_o(cyc_o[0]), .flush_count_o(cnt_o[0])
`endif
  );

  commit_flush_sequencer #(.PC_WIDTH(PCW), .ICACHE_FLUSH_CYCLES(4)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave)
`ifdef FLUSH_PERF_CNT_EN
    , .flush_cycles_o(cyc_o[1]), .flush_count_o(cnt_o[1])
`endif
  );

  // {busy, dcache, icache, tlb, pipeline, set_pc, restart_pc}
  logic [PCW+5:0] out_v [2];
  assign out_v[0] = {bus0.busy_o, bus0.flush_dcache_o, bus0.flush_icache_o, bus0.flush_tlb_o,
                     bus0.flush_pipeline_o, bus0.set_pc_o, bus0.restart_pc_o};
  assign out_v[1] = {bus1.busy_o, bus1.flush_dcache_o, bus1.flush_icache_o, bus1.flush_tlb_o,
                     bus1.flush_pipeline_o, bus1.set_pc_o, bus1.restart_pc_o};

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int n_ic(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // Schedule model: each sequence is described by the cycle numbers at which
  // its TLB flush, I$ window and restart fall, plus an open D$ wait.
  int             n;
  bit             m_wait [2];
  bit             m_fi   [2];
  int             tlb_at [2], rs_at [2], ic_from [2], ic_to [2];
  logic [PCW-1:0] m_pc   [2];
  logic [31:0]    m_cyc  [2];
  logic [15:0]    m_cnt  [2];

  initial begin : compare
    logic [PCW+5:0] e;
    bit e_busy, e_rs;
    n = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        n = 0;
        for (int i = 0; i < 2; i++) begin
          m_wait[i] = 0; m_fi[i] = 0; tlb_at[i] = -1; rs_at[i] = -1;
          ic_from[i] = 1; ic_to[i] = 0; m_pc[i] = '0; m_cyc[i] = '0; m_cnt[i] = '0;
          check($sformatf("rst_out%0d", i), out_v[i], '0);
`ifdef FLUSH_PERF_CNT_EN
          check($sformatf("rst_perf%0d", i), {cyc_o[i], cnt_o[i]}, '0);
`endif
        end
      end else begin
        for (int i = 0; i < 2; i++) begin
          e_rs   = (n == rs_at[i]);
          e_busy = m_wait[i] || (n <= rs_at[i]);
          e = {e_busy, m_wait[i], (n >= ic_from[i] && n <= ic_to[i]), (n == tlb_at[i]),
               e_rs, e_rs, (e_rs ? m_pc[i] : {PCW{1'b0}})};
          check($sformatf("out%0d_c%0d", i, n), out_v[i], e);
`ifdef FLUSH_PERF_CNT_EN
          check($sformatf("perf%0d_c%0d", i, n), {cyc_o[i], cnt_o[i]}, {m_cyc[i], m_cnt[i]});
`endif
          if (e_busy && m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
          if (e_rs) m_cnt[i] = m_cnt[i] + 1;
          if (!e_busy) begin
            if ((fence || fence_i || sfence) && !ex && !halt) begin
              m_pc[i] = pc + 64'd4;
              if (fence || fence_i) begin
                m_wait[i] = 1; m_fi[i] = fence_i;
              end else begin
                tlb_at[i] = n + 1; rs_at[i] = n + 2;
              end
            end
          end else if (m_wait[i] && ack) begin
            m_wait[i] = 0;
            if (m_fi[i]) begin
              ic_from[i] = n + 1; ic_to[i] = n + n_ic(i); rs_at[i] = n + n_ic(i) + 1;
            end else begin
              rs_at[i] = n + 1;
            end
          end
        end
        n++;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
    fence = 0; fence_i = 0; sfence = 0; ex = 0; halt = 0; ack = 0;
  endtask

  task automatic wait_idle();
    int k;
    for (k = 0; k < 40 && (bus0.busy_o || bus1.busy_o); k++) tick();
    check("idle_timeout", {bus0.busy_o, bus1.busy_o}, '0);
  endtask

  task automatic do_reset();
    rst_n = 0; tick(); tick(); rst_n = 1; tick();
  endtask

  initial begin : stim
    rst_n = 0; fence = 0; fence_i = 0; sfence = 0; ex = 0; halt = 0; ack = 0; pc = '0;
    tick(); tick(); rst_n = 1;

    // FENCE.I, ack at cycle 5
    tick(); fence_i = 1; pc = 64'h8000_0100;
    for (int c = 1; c <= 8; c++) begin
      tick(); if (c == 5) ack = 1;
      @(negedge clk);
      if (c <= 5) check("fi_dcache", bus0.flush_dcache_o, 1'b1);
      if (c == 6) check("fi_icache", {bus0.flush_icache_o, bus0.flush_dcache_o}, 2'b10);
      if (c == 7) check("fi_restart", {bus0.set_pc_o, bus0.flush_pipeline_o, bus0.restart_pc_o},
                        {2'b11, 64'h8000_0104});
      if (c == 8) check("fi_idle", bus0.busy_o, 1'b0);
    end
    wait_idle();

    // SFENCE.VMA
    tick(); sfence = 1; pc = 64'h1000;
    for (int c = 1; c <= 3; c++) begin
      tick(); @(negedge clk);
      if (c == 1) check("sf_tlb", {bus0.flush_tlb_o, bus0.flush_dcache_o}, 2'b10);
      if (c == 2) check("sf_restart", {bus0.flush_tlb_o, bus0.set_pc_o, bus0.restart_pc_o},
                        {2'b01, 64'h1004});
      if (c == 3) check("sf_idle", bus1.busy_o, 1'b0);
    end

    // FENCE + SFENCE.VMA together, PC wraps
    tick(); fence = 1; sfence = 1; pc = 64'hFFFF_FFFF_FFFF_FFFC;
    for (int c = 1; c <= 5; c++) begin
      tick(); if (c == 3) ack = 1;
      @(negedge clk);
      if (c <= 3) check("fs_dcache", {bus0.flush_dcache_o, bus0.flush_tlb_o}, 2'b10);
      if (c == 4) check("fs_restart", {bus0.set_pc_o, bus0.restart_pc_o}, {1'b1, 64'h0});
      if (c == 5) check("fs_idle", bus0.busy_o, 1'b0);
    end

    // Dropped requests
    tick(); fence_i = 1; ex = 1;
    tick(); @(negedge clk); check("ex_drop", out_v[0], '0);
    tick(); fence_i = 1; halt = 1;
    tick(); @(negedge clk); check("halt_drop", out_v[1], '0);

    // Reset while waiting for ack
    tick(); fence = 1; pc = 64'h40;
    for (int c = 1; c <= 11; c++) begin
      tick();
      if (c == 3) begin
        rst_n = 0; #1;
        check("midrst", {out_v[0], out_v[1]}, '0);
      end
      if (c == 4) rst_n = 1;
      if (c == 6) ack = 1;
      if (c == 8) begin fence = 1; pc = 64'h2000; end
      if (c == 10) ack = 1;
      @(negedge clk);
      if (c == 7) check("late_ack", {bus0.busy_o, bus0.set_pc_o}, 2'b00);
      if (c == 9) check("re_accept", {bus0.busy_o, bus0.flush_dcache_o}, 2'b11);
      if (c == 11) check("re_restart", {bus0.set_pc_o, bus0.restart_pc_o}, {1'b1, 64'h2004});
    end
    wait_idle();

    // 4-cycle I$ flush, ack at cycle 2
    do_reset();
    fence_i = 1; pc = 64'h300;
    for (int c = 1; c <= 8; c++) begin
      tick(); if (c == 2) ack = 1;
      @(negedge clk);
      if (c >= 3 && c <= 6) check("ic4_icache", bus1.flush_icache_o, 1'b1);
      if (c == 7) check("ic4_restart", {bus1.flush_icache_o, bus1.set_pc_o, bus1.restart_pc_o},
                        {2'b01, 64'h304});
      if (c == 8) begin
        check("ic4_idle", bus1.busy_o, 1'b0);
`ifdef FLUSH_PERF_CNT_EN
        check("ic4_perf1", {cyc_o[1], cnt_o[1]}, {32'd7, 16'd1});
        check("ic4_perf0", {cyc_o[0], cnt_o[0]}, {32'd4, 16'd1});
`endif
      end
    end

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 399) == 0) rst_n = 0;
      fence_i = ($urandom_range(0, 5) == 0);
      fence   = ($urandom_range(0, 5) == 0);
      sfence  = ($urandom_range(0, 5) == 0);
      ex      = ($urandom_range(0, 7) == 0);
      halt    = ($urandom_range(0, 7) == 0);
      ack     = ($urandom_range(0, 2) == 0);
      pc      = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
    end
    rst_n = 1;
    ack = 1; tick(); ack = 1; tick(); ack = 1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
